ct_spsram_req_ctrl: RTL and testbench



---
 rtl/ct_spsram_pkg.sv | 17 +
 rtl/ct_spsram_req_ctrl_if.sv | 28 ++
 rtl/ct_spsram_rsp_fifo.sv | 69 ++++++
 rtl/ct_spsram_req_ctrl.sv | 97 +++++++++
 tb/tb_ct_spsram_req_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_spsram_pkg.sv
// Shared constants for the single-port SRAM request controller: SRAM geometry,
// idle levels of the active-low SRAM pins and the request-type encoding.
package ct_spsram_pkg;

    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned DATA_WIDTH = 128;

    localparam logic                  CEN_IDLE  = 1'b1;
    localparam logic                  GWEN_IDLE = 1'b1;
    localparam logic [DATA_WIDTH-1:0] WEN_IDLE  = '1;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;

endpackage

// File: rtl/ct_spsram_req_ctrl_if.sv
// Request/response handshake bundle between a cache/buffer controller (master)
// and the SRAM request controller (slave).
interface ct_spsram_req_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = ct_spsram_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ct_spsram_pkg::DATA_WIDTH
);

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_bmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_bmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_bmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );

endinterface

// File: rtl/ct_spsram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; pointers wrap modulo DEPTH so
// non-power-of-two depths work.
module ct_spsram_rsp_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 128,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count
);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries below count are ever presented.
    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    a_no_overflow : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        !(push && !pop && (count_q == CntW'(DEPTH))));
    a_no_underflow : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        !(pop && (count_q == '0)));

endmodule

// File: rtl/ct_spsram_req_ctrl.sv
// Valid/ready front end for a 1-cycle-latency single-port SRAM: drives the
// active-low SRAM pins, tracks the in-flight read and buffers read data.
module ct_spsram_req_ctrl #(
    parameter int unsigned ADDR_WIDTH = ct_spsram_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ct_spsram_pkg::DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = 3
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    ct_spsram_req_ctrl_if.slave     bus,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q,
    output logic                    ctrl_idle
);

    import ct_spsram_pkg::*;

    localparam int unsigned  CntW   = $clog2(RSP_DEPTH + 1);
    localparam logic [CntW:0] DepthC = (CntW + 1)'(RSP_DEPTH);

    logic                  acc;
    logic                  push;
    logic                  pop;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [CntW-1:0]       fifo_count;
    logic [CntW:0]         credit;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    // Every slot is reserved at accept time, so a read can never find the FIFO full.
    assign credit      = DepthC - {1'b0, fifo_count} - {{CntW{1'b0}}, rd_inflight_q};
    assign bus.req_rdy = cpurst_b & (credit != '0);
    assign acc         = bus.req_vld & bus.req_rdy;

    assign rd_inflight_d = acc & (bus.req_wr != REQ_WR);
    assign push          = cpurst_b & rd_inflight_q;
    assign pop           = bus.rsp_vld & bus.rsp_rdy;

    always_comb begin
        sram_cen  = CEN_IDLE;
        sram_gwen = GWEN_IDLE;
        sram_wen  = {DATA_WIDTH{WEN_IDLE[0]}};
        sram_a    = a_q;
        sram_d    = d_q;
        if (acc) begin
            sram_cen = ~CEN_IDLE;
            sram_a   = bus.req_addr;
            sram_d   = bus.req_wdata;
            if (bus.req_wr == REQ_WR) begin
                sram_gwen = ~GWEN_IDLE;
                sram_wen  = ~bus.req_bmask;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_inflight_q <= 1'b0;
            a_q           <= '0;
            d_q           <= '0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            if (acc) begin
                a_q <= bus.req_addr;
                d_q <= bus.req_wdata;
            end
        end
    end

    ct_spsram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .push           (push),
        .wdata          (sram_q),
        .pop            (pop),
        .rdata          (fifo_rdata),
        .count          (fifo_count)
    );

    assign bus.rsp_vld   = cpurst_b & (fifo_count != '0);
    assign bus.rsp_rdata = fifo_rdata;
    assign ctrl_idle     = ~cpurst_b | (~rd_inflight_q & (fifo_count == '0));

    a_push_follows_read : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        push |-> $past(rd_inflight_d));
    a_credit_bounded : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        ({1'b0, fifo_count} + {{CntW{1'b0}}, rd_inflight_q}) <= DepthC);

endmodule

// File: tb/tb_ct_spsram_req_ctrl.sv
// Directed bench for ct_spsram_req_ctrl with a behavioural SRAM and a
// scoreboard queue of expected read data checked by a separate monitor.
module tb_ct_spsram_req_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 128;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b       = 1'b0;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic          ctrl_idle;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] exp_q [$];

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int pop_total    = 0;
    int last_pop_cyc = 0;
    int last_acc_cyc = 0;

    ct_spsram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_spsram_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (3)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .bus            (bus),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q),
        .ctrl_idle      (ctrl_idle)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    // Behavioural SRAM: active-low CEN/GWEN/WEN, Q registered one cycle after a read.
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    function automatic logic [DW-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i) + 8'h30;
        return {16{b}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge forever_cpuclk);
            if (bus.rsp_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", bus.rsp_vld, 1'b0);
                end else begin
                    check("rsp_rdata", bus.rsp_rdata, exp_q[0]);
                    if (bus.rsp_rdy) begin
                        void'(exp_q.pop_front());
                        pop_total++;
                        last_pop_cyc = cyc;
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge with req_vld low.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] bmask, input logic expect_rsp,
                         input logic [DW-1:0] exp, output int waits);
        logic accepted;
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_bmask = bmask;
        waits         = 0;
        accepted      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge forever_cpuclk);
            if (bus.req_rdy) begin
                accepted = 1'b1;
                break;
            end
            waits++;
            step();
        end
        if (!accepted) begin
            check("accept_timeout", bus.req_rdy, 1'b1);
        end else begin
            check("sram_cen_acc", sram_cen, 1'b0);
            check("sram_gwen_acc", sram_gwen, !wr);
            check("sram_wen_acc", sram_wen, wr ? ~bmask : {DW{1'b1}});
            check("sram_a_acc", sram_a, addr);
            if (wr) check("sram_d_acc", sram_d, wdata);
            if (!wr && expect_rsp) exp_q.push_back(exp);
            last_acc_cyc = cyc;
        end
        step();
        bus.req_vld = 1'b0;
    endtask

    initial begin
        int w;
        int p0;
        int c_last;
        bus.req_vld   = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_bmask = '0;
        bus.rsp_rdy   = 1'b1;
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: time %0t reached limit 100000", $time);
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset held with a pending request
        repeat (3) begin
            @(negedge forever_cpuclk);
            check("rst_sram_cen", sram_cen, 1'b1);
            check("rst_rsp_vld", bus.rsp_vld, 1'b0);
            check("rst_req_rdy", bus.req_rdy, 1'b0);
            check("rst_ctrl_idle", ctrl_idle, 1'b1);
        end
        step();
        cpurst_b    = 1'b1;
        bus.req_vld = 1'b0;
        @(negedge forever_cpuclk);
        check("post_rst_req_rdy", bus.req_rdy, 1'b1);
        check("post_rst_idle", ctrl_idle, 1'b1);
        step();

        // Write then back-to-back read of the same address
        issue(1'b1, 10'h3FF, {16{8'hA5}}, {DW{1'b1}}, 1'b0, '0, w);
        issue(1'b0, 10'h3FF, '0, '0, 1'b1, {16{8'hA5}}, w);
        @(negedge forever_cpuclk);
        check("rd_lat_t1_vld", bus.rsp_vld, 1'b0);
        step();
        @(negedge forever_cpuclk);
        check("rd_lat_t2_vld", bus.rsp_vld, 1'b1);
        step();

        // Partial bit mask
        issue(1'b1, 10'd5, '0, {DW{1'b1}}, 1'b0, '0, w);
        issue(1'b1, 10'd5, {DW{1'b1}}, 128'hFF, 1'b0, '0, w);
        issue(1'b0, 10'd5, '0, '0, 1'b1, 128'hFF, w);
        repeat (3) step();

        // Streaming reads
        for (int i = 0; i < 16; i++) issue(1'b1, AW'(i), pat(i), {DW{1'b1}}, 1'b0, '0, w);
        repeat (2) step();
        p0 = pop_total;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, AW'(i), '0, '0, 1'b1, pat(i), w);
            check("stream_wait", w, 0);
        end
        c_last = last_acc_cyc;
        repeat (4) step();
        check("stream_rsp_count", pop_total - p0, 16);
        check("stream_last_pop_cyc", last_pop_cyc, c_last + 2);

        // Backpressure: three reads fit, the fourth stalls until a pop frees credit
        bus.rsp_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            issue(1'b0, AW'(i), '0, '0, 1'b1, pat(i), w);
            check("bp_wait", w, 0);
        end
        bus.req_vld  = 1'b1;
        bus.req_wr   = 1'b0;
        bus.req_addr = 10'd4;
        repeat (4) begin
            @(negedge forever_cpuclk);
            check("bp_req_rdy", bus.req_rdy, 1'b0);
            check("bp_rsp_vld", bus.rsp_vld, 1'b1);
            step();
        end
        bus.rsp_rdy = 1'b1;
        issue(1'b0, 10'd4, '0, '0, 1'b1, pat(4), w);
        check("bp_resume_wait", w, 1);
        repeat (6) step();
        @(negedge forever_cpuclk);
        check("bp_drained_idle", ctrl_idle, 1'b1);
        step();

        // Reset while a read is in flight: its data must never surface
        issue(1'b0, 10'd7, '0, '0, 1'b0, '0, w);
        cpurst_b = 1'b0;
        @(negedge forever_cpuclk);
        check("midrst_req_rdy", bus.req_rdy, 1'b0);
        check("midrst_rsp_vld", bus.rsp_vld, 1'b0);
        step();
        step();
        cpurst_b = 1'b1;
        repeat (5) begin
            @(negedge forever_cpuclk);
            check("midrst_after_rsp_vld", bus.rsp_vld, 1'b0);
            check("midrst_after_idle", ctrl_idle, 1'b1);
            check("midrst_after_req_rdy", bus.req_rdy, 1'b1);
            step();
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
